// File: rtl/seven_seg_scan_ctrl.sv
// seven_seg_scan_ctrl: time-multiplexed scan controller for a 4-digit
// common-cathode 7-segment display fed by an external BCD decoder.
// A new BCD value is taken over valid/ready into a shadow register and
// committed to o_BCD only at frame starts (or on disable), so digits never tear.
// Optional build macro: LEADING_ZERO_BLANK_EN blanks leading-zero digits 1..3.
module seven_seg_scan_ctrl #(
   parameter int unsigned DIGIT_CYCLES = 50000,
   parameter int unsigned BLANK_CYCLES = 500
) (
   input  logic        i_clk,
   input  logic        i_rst,
   input  logic        i_en,
   input  logic [15:0] i_BCD,
   input  logic        i_valid,
   output logic        o_ready,
   output logic [15:0] o_BCD,
   input  logic [7:0]  i_data_1,
   input  logic [7:0]  i_data_2,
   input  logic [7:0]  i_data_3,
   input  logic [7:0]  i_data_4,
   output logic [7:0]  o_seg,
   output logic [3:0]  o_digit,
   output logic        o_frame
);

   localparam int unsigned CW = (DIGIT_CYCLES > 1) ? $clog2(DIGIT_CYCLES) : 1;

   typedef enum logic {
      ST_BLANK,
      ST_ON
   } state_t;

   state_t        state, state_n;
   logic [CW-1:0] cnt, cnt_n;
   logic [1:0]    idx, idx_n;
   logic          en_d;
   logic          frame_n;
   logic [15:0]   shadow;
   logic [3:0]    lz_blank;
   logic [7:0]    seg_sel;
   logic          commit;

   // Next slot counter, digit index, frame strobe and scan state
   always_comb begin
      cnt_n   = '0;
      idx_n   = '0;
      frame_n = 1'b0;
      if (i_en) begin
         if (!en_d) begin
            frame_n = 1'b1;
         end else if (cnt == CW'(DIGIT_CYCLES - 1)) begin
            idx_n   = idx + 2'd1;
            frame_n = (idx == 2'd3);
         end else begin
            cnt_n = cnt + CW'(1);
            idx_n = idx;
         end
      end
      // Counter only ever returns to 0 on wrap/restart/disable, and BLANK_CYCLES >= 1,
      // so these two points fully define the BLANK/ON boundaries.
      if (cnt_n == '0)
         state_n = ST_BLANK;
      else if (cnt_n == CW'(BLANK_CYCLES))
         state_n = ST_ON;
      else
         state_n = state;
   end

   // Leading-zero mask and decoder output selection for the upcoming digit
   always_comb begin
      lz_blank = '0;
`ifdef LEADING_ZERO_BLANK_EN
      lz_blank[0] = (o_BCD[15:12] == 4'h0);
      lz_blank[1] = lz_blank[0] && (o_BCD[11:8] == 4'h0);
      lz_blank[2] = lz_blank[1] && (o_BCD[7:4] == 4'h0);
`else
      lz_blank = '0;
`endif
      case (idx_n)
         2'd0:    seg_sel = i_data_1;
         2'd1:    seg_sel = i_data_2;
         2'd2:    seg_sel = i_data_3;
         default: seg_sel = i_data_4;
      endcase
      if (lz_blank[idx_n])
         seg_sel = '0;
      commit = !o_ready && (frame_n || !i_en);
   end

   // Scan FSM, registered display outputs and shadow-register handshake
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         state   <= ST_BLANK;
         cnt     <= '0;
         idx     <= '0;
         en_d    <= 1'b0;
         o_frame <= 1'b0;
         o_digit <= '0;
         o_seg   <= '0;
         o_BCD   <= '0;
         shadow  <= '0;
         o_ready <= 1'b1;
      end else begin
         state   <= state_n;
         cnt     <= cnt_n;
         idx     <= idx_n;
         en_d    <= i_en;
         o_frame <= frame_n;
         if (state_n == ST_ON) begin
            o_digit <= 4'b1000 >> idx_n;
            o_seg   <= seg_sel;
         end else begin
            o_digit <= '0;
            o_seg   <= '0;
         end
         // o_ready low means the shadow is full, so commit and accept are exclusive
         if (commit) begin
            o_BCD   <= shadow;
            o_ready <= 1'b1;
         end else if (i_valid && o_ready) begin
            shadow  <= i_BCD;
            o_ready <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_seven_seg_scan_ctrl.sv
// Self-checking bench for seven_seg_scan_ctrl with DIGIT_CYCLES=8, BLANK_CYCLES=2.
// A behavioural hex-to-7-segment decoder is driven from o_BCD.
module tb_seven_seg_scan_ctrl;

   localparam int DC = 8;
   localparam int BC = 2;

   logic        clk = 1'b0;
   logic        rst;
   logic        en;
   logic [15:0] bcd_in;
   logic        valid;
   logic        ready;
   logic [15:0] obcd;
   logic [7:0]  d1, d2, d3, d4;
   logic [7:0]  seg;
   logic [3:0]  digit;
   logic        frame;

   int tests = 0;
   int fails = 0;

   always #5 clk = ~clk;

   seven_seg_scan_ctrl #(.DIGIT_CYCLES(DC), .BLANK_CYCLES(BC)) dut (
      .i_clk(clk), .i_rst(rst), .i_en(en), .i_BCD(bcd_in), .i_valid(valid),
      .o_ready(ready), .o_BCD(obcd),
      .i_data_1(d1), .i_data_2(d2), .i_data_3(d3), .i_data_4(d4),
      .o_seg(seg), .o_digit(digit), .o_frame(frame)
   );

   function automatic logic [7:0] dec(input logic [3:0] n);
      case (n)
         4'h0: return 8'h3F; 4'h1: return 8'h06; 4'h2: return 8'h5B; 4'h3: return 8'h4F;
         4'h4: return 8'h66; 4'h5: return 8'h6D; 4'h6: return 8'h7D; 4'h7: return 8'h07;
         4'h8: return 8'h7F; 4'h9: return 8'h6F; 4'hA: return 8'h77; 4'hB: return 8'h7C;
         4'hC: return 8'h39; 4'hD: return 8'h5E; 4'hE: return 8'h79; default: return 8'h71;
      endcase
   endfunction

   assign d1 = dec(obcd[15:12]);
   assign d2 = dec(obcd[11:8]);
   assign d3 = dec(obcd[7:4]);
   assign d4 = dec(obcd[3:0]);

   // Expected digit enable for slot counter c and digit index k
   function automatic logic [3:0] exp_digit(input int c, input int k);
      logic [3:0] one;
      one = 4'b1000;
      if (c < BC) return 4'b0000;
      return one >> k;
   endfunction

   // Expected segment pattern for digit index k (0 = leftmost) showing value v
   function automatic logic [7:0] exp_seg(input int k, input logic [15:0] v);
      logic [3:0] n;
      logic       all0;
      n    = v[(15-4*k) -: 4];
      all0 = 1'b1;
`ifdef LEADING_ZERO_BLANK_EN
      if (k < 3) begin
         for (int j = 0; j <= k; j++)
            if (v[(15-4*j) -: 4] != 4'h0) all0 = 1'b0;
         if (all0) return 8'h00;
      end
`else
      all0 = 1'b0;
      if (all0) return 8'h00;
`endif
      return dec(n);
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic step(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #1;
      end
   endtask

   // Advance until the edge that raises o_frame, bounded
   task automatic wait_frame();
      int  cyc;
      bit  seen;
      seen = 1'b0;
      cyc  = 0;
      while (!seen && cyc < 40) begin
         step(1);
         cyc++;
         if (frame) seen = 1'b1;
      end
      if (!seen) begin
         fails++;
         tests++;
         $display("FAIL wait_frame: no o_frame within 40 cycles, got 0 expected 1");
      end
   endtask

   typedef struct {
      logic        en;
      logic        valid;
      logic [15:0] bcd;
      logic [3:0]  e_digit;
      logic        e_frame;
      logic        e_ready;
      logic [15:0] e_obcd;
      logic [7:0]  e_seg;
   } vec_t;

   vec_t vt[40];

   initial begin
      // Table: first 40 enabled cycles, one accept of 0123 at cycle 10
      for (int i = 0; i < 40; i++) begin
         int c, k;
         c = i % DC;
         k = (i / DC) % 4;
         vt[i].en      = 1'b1;
         vt[i].valid   = (i == 10);
         vt[i].bcd     = (i == 10) ? 16'h0123 : 16'h0000;
         vt[i].e_digit = exp_digit(c, k);
         vt[i].e_frame = (i % 32 == 0);
         vt[i].e_ready = !(i >= 10 && i < 32);
         vt[i].e_obcd  = (i >= 32) ? 16'h0123 : 16'h0000;
         vt[i].e_seg   = (vt[i].e_digit == 4'b0000) ? 8'h00 : exp_seg(k, vt[i].e_obcd);
      end

      rst = 1'b1; en = 1'b0; valid = 1'b0; bcd_in = '0;
      #12;
      check("reset_digit", {28'd0, digit}, 32'd0);
      check("reset_seg", {24'd0, seg}, 32'd0);
      check("reset_obcd", {16'd0, obcd}, 32'd0);
      check("reset_ready", {31'd0, ready}, 32'd1);
      check("reset_frame", {31'd0, frame}, 32'd0);
      rst = 1'b0;
      step(1);
      check("idle_frame", {31'd0, frame}, 32'd0);

      // Scan sequence and first handshake from the table
      for (int i = 0; i < 40; i++) begin
         en = vt[i].en; valid = vt[i].valid; bcd_in = vt[i].bcd;
         step(1);
         check($sformatf("tbl%0d_digit", i), {28'd0, digit}, {28'd0, vt[i].e_digit});
         check($sformatf("tbl%0d_frame", i), {31'd0, frame}, {31'd0, vt[i].e_frame});
         check($sformatf("tbl%0d_ready", i), {31'd0, ready}, {31'd0, vt[i].e_ready});
         check($sformatf("tbl%0d_obcd", i), {16'd0, obcd}, {16'd0, vt[i].e_obcd});
         check($sformatf("tbl%0d_seg", i), {24'd0, seg}, {24'd0, vt[i].e_seg});
      end
      valid = 1'b0;

      // Value presented while full is ignored; the accepted one commits
      valid = 1'b1; bcd_in = 16'h8901;
      step(1);
      check("acc8901_ready", {31'd0, ready}, 32'd0);
      bcd_in = 16'hFAC0;
      step(3);
      valid = 1'b0;
      wait_frame();
      check("commit8901", {16'd0, obcd}, 32'h8901);
      check("commit8901_ready", {31'd0, ready}, 32'd1);
      valid = 1'b1; bcd_in = 16'hFAC0;
      step(1);
      valid = 1'b0;
      check("holdFAC0_obcd", {16'd0, obcd}, 32'h8901);
      check("holdFAC0_ready", {31'd0, ready}, 32'd0);
      step(2);
      check("d1on_8901_digit", {28'd0, digit}, 32'b1000);
      check("d1on_8901_seg", {24'd0, seg}, {24'd0, exp_seg(0, 16'h8901)});
      wait_frame();
      check("commitFAC0", {16'd0, obcd}, 32'hFAC0);
      step(3);
      check("d1on_FAC0_seg", {24'd0, seg}, {24'd0, exp_seg(0, 16'hFAC0)});

      // Accept coincident with a frame start commits one frame later
      step(28);
      valid = 1'b1; bcd_in = 16'h4567;
      step(1);
      valid = 1'b0;
      check("coinc_frame", {31'd0, frame}, 32'd1);
      check("coinc_obcd", {16'd0, obcd}, 32'hFAC0);
      check("coinc_ready", {31'd0, ready}, 32'd0);
      step(31);
      check("coinc_pre_obcd", {16'd0, obcd}, 32'hFAC0);
      check("coinc_pre_frame", {31'd0, frame}, 32'd0);
      step(1);
      check("coinc_commit_frame", {31'd0, frame}, 32'd1);
      check("coinc_commit_obcd", {16'd0, obcd}, 32'h4567);
      check("coinc_commit_ready", {31'd0, ready}, 32'd1);

      // Disable during digit 3 ON with a pending value, then re-enable
      valid = 1'b1; bcd_in = 16'h0012;
      step(1);
      valid = 1'b0;
      check("pend0012_ready", {31'd0, ready}, 32'd0);
      step(18);
      check("d3on_digit", {28'd0, digit}, 32'b0010);
      en = 1'b0;
      step(1);
      check("dis_digit", {28'd0, digit}, 32'd0);
      check("dis_seg", {24'd0, seg}, 32'd0);
      check("dis_frame", {31'd0, frame}, 32'd0);
      check("dis_commit", {16'd0, obcd}, 32'h0012);
      check("dis_ready", {31'd0, ready}, 32'd1);
      step(3);
      check("dis_hold_digit", {28'd0, digit}, 32'd0);
      check("dis_hold_frame", {31'd0, frame}, 32'd0);
      en = 1'b1;
      step(1);
      check("reen_frame", {31'd0, frame}, 32'd1);
      check("reen_digit", {28'd0, digit}, 32'd0);
      for (int j = 1; j < 32; j++) begin
         step(1);
         check($sformatf("f0012_%0d_digit", j), {28'd0, digit}, {28'd0, exp_digit(j % DC, j / DC)});
         check($sformatf("f0012_%0d_seg", j), {24'd0, seg},
               (exp_digit(j % DC, j / DC) == 4'b0000) ? 32'd0 : {24'd0, exp_seg(j / DC, 16'h0012)});
      end

      // Asynchronous reset mid-frame discards the pending shadow value
      step(4);
      valid = 1'b1; bcd_in = 16'h9999;
      step(1);
      valid = 1'b0;
      check("pre_rst_digit", {28'd0, digit}, 32'b1000);
      #3;
      rst = 1'b1;
      #1;
      check("arst_digit", {28'd0, digit}, 32'd0);
      check("arst_seg", {24'd0, seg}, 32'd0);
      check("arst_obcd", {16'd0, obcd}, 32'd0);
      check("arst_ready", {31'd0, ready}, 32'd1);
      check("arst_frame", {31'd0, frame}, 32'd0);
      step(1);
      rst = 1'b0;
      wait_frame();
      check("post_rst_digit", {28'd0, digit}, 32'd0);
      wait_frame();
      check("post_rst_obcd", {16'd0, obcd}, 32'd0);
      check("post_rst_ready", {31'd0, ready}, 32'd1);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
